// File: rtl/operand_pair_sequencer_pkg.sv
// Shared definitions for the operand pair sequencer.
//   DEFAULT_DATA_WIDTH : default operand width (adder input width)
//   seq_state_t        : pairing FSM states
//   pair_t             : one buffered operand pair at the default width
package operand_pair_sequencer_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic {
        EMPTY_A = 1'b0,   // no word held
        HAVE_A  = 1'b1    // first word of a pair is held in hold_a
    } seq_state_t;

    typedef struct packed {
        logic [DEFAULT_DATA_WIDTH-1:0] a;
        logic [DEFAULT_DATA_WIDTH-1:0] b;
        logic                          odd;
    } pair_t;

endpackage

// File: rtl/operand_pair_sequencer_pair_fifo.sv
// Synchronous show-ahead FIFO holding packed operand pairs.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   push, push_data : write request and entry
//   pop          : consume head entry
//   head         : current head entry, all zeros when empty
//   full, empty  : occupancy flags
module operand_pair_sequencer_pair_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [AW:0] ptr_t;

    logic [WIDTH-1:0] mem [DEPTH];
    ptr_t             wr_ptr;
    ptr_t             rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop frees the slot in the same cycle, so a push into a full FIFO is legal then.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: storage array has no reset; pointers alone define validity, and
    // leaving the data unreset lets it map onto plain RAM/flops without reset muxes.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
            if (do_pop)  rd_ptr <= rd_ptr + ptr_t'(1);
        end
    end

    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/operand_pair_sequencer.sv
// Pairs consecutive stream words into (a, b) operand pairs for the adder stage.
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   s_valid/s_ready       : input word handshake; s_data word, s_last ends burst
//   m_valid/m_ready       : output pair handshake
//   m_a, m_b, m_odd       : head pair; m_odd marks a final word paired with zero
//   pair_count            : pairs popped since reset, wrapping
module operand_pair_sequencer
    import operand_pair_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_a,
    output logic [DATA_WIDTH-1:0] m_b,
    output logic                  m_odd,
    output logic [CNT_WIDTH-1:0]  pair_count
);

    localparam int PAIR_W = 2 * DATA_WIDTH + 1;

    seq_state_t            state;
    logic [DATA_WIDTH-1:0] hold_a;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic [PAIR_W-1:0]     push_data;
    logic [PAIR_W-1:0]     head;
    logic                  full;
    logic                  empty;

    assign m_valid = !empty;
    assign pop     = m_valid && m_ready;

    // Readiness ignores the FSM state: even a word that would only be held waits
    // for FIFO space, keeping the ready path independent of pairing state.
    assign s_ready = !full || pop;
    assign accept  = s_valid && s_ready;

    // A pair completes on the second word, or on a lone final word of a burst.
    assign push = accept && ((state == HAVE_A) || s_last);

    assign push_data = (state == HAVE_A) ? {hold_a, s_data, 1'b0}
                                         : {s_data, {DATA_WIDTH{1'b0}}, 1'b1};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= EMPTY_A;
            hold_a <= '0;
        end else if (accept) begin
            case (state)
                EMPTY_A: begin
                    if (!s_last) begin
                        hold_a <= s_data;
                        state  <= HAVE_A;
                    end
                end
                HAVE_A:  state <= EMPTY_A;
                default: state <= EMPTY_A;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pair_count <= '0;
        end else if (pop) begin
            pair_count <= pair_count + CNT_WIDTH'(1);
        end
    end

    operand_pair_sequencer_pair_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (DEPTH)
    ) u_pair_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign {m_a, m_b, m_odd} = head;

endmodule
